// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the 4-bit universal shift register and its command sequencer.
package shift_reg_pkg;

  localparam int SR_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_LOAD  = 2'b11
  } sr_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE
  } seq_state_t;

endpackage

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for the universal shift register: load, N shifts, capture, done pulse.
// Optional build macro SHIFT_ZERO_EARLY_EXIT_EN: stop shifting once the register is zero with fill 0.
module shift_cmd_sequencer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_p_in,
  output logic             sr_s_in,
  input  logic [WIDTH-1:0] sr_q_out,
  input  logic             sr_is_zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_zero,
  output logic [CNT_W-1:0] shifts_done
);

  seq_state_t       state_q;
  logic             dir_q;
  logic [CNT_W-1:0] remain_q;
  logic [CNT_W-1:0] shifts_q;
  logic [CNT_W-1:0] count_clamped;
  logic             early_exit;
  sr_mode_t         mode_s;

  assign count_clamped = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;

  // Once the register holds zero and the fill is zero, further shifts cannot change it.
`ifdef SHIFT_ZERO_EARLY_EXIT_EN
  assign early_exit = sr_is_zero && !sr_s_in;
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    mode_s = MODE_HOLD;
    case (state_q)
      LOAD:    mode_s = MODE_LOAD;
      SHIFT:   mode_s = dir_q ? MODE_RIGHT : MODE_LEFT;
      default: mode_s = MODE_HOLD;
    endcase
  end

  assign sr_mode = mode_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dir_q       <= 1'b0;
      remain_q    <= '0;
      shifts_q    <= '0;
      sr_p_in     <= '0;
      sr_s_in     <= 1'b0;
      result      <= '0;
      result_zero <= 1'b0;
      shifts_done <= '0;
    end else begin
      done      <= 1'b0;
      cmd_ready <= (state_q == IDLE) && !(cmd_valid && cmd_ready);
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            sr_p_in   <= cmd_data;
            sr_s_in   <= cmd_fill;
            dir_q     <= cmd_dir;
            remain_q  <= count_clamped;
            shifts_q  <= '0;
            busy      <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          state_q <= (remain_q != '0) ? SHIFT : CAPTURE;
        end
        SHIFT: begin
          if (early_exit) begin
            // Register is already final: capture in this cycle instead of a separate CAPTURE.
            result      <= sr_q_out;
            result_zero <= sr_is_zero;
            shifts_done <= shifts_q;
            done        <= 1'b1;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            remain_q <= remain_q - CNT_W'(1);
            shifts_q <= shifts_q + CNT_W'(1);
            if (remain_q == CNT_W'(1)) state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          result      <= sr_q_out;
          result_zero <= sr_is_zero;
          shifts_done <= shifts_q;
          done        <= 1'b1;
          busy        <= 1'b0;
          cmd_ready   <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer driving a behavioural 4-bit universal shift register.
module tb_shift_cmd_sequencer;

  localparam int W = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_fill = 1'b0;
  logic [1:0]    sr_mode;
  logic [W-1:0]  sr_p_in;
  logic          sr_s_in;
  logic [W-1:0]  sr_q = '0;
  logic          sr_is_zero;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          result_zero;
  logic [CW-1:0] shifts_done;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    int           shifts;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done = -1;

  shift_cmd_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .sr_mode(sr_mode), .sr_p_in(sr_p_in), .sr_s_in(sr_s_in),
    .sr_q_out(sr_q), .sr_is_zero(sr_is_zero),
    .busy(busy), .done(done), .result(result), .result_zero(result_zero),
    .shifts_done(shifts_done)
  );

  always #5 clk = ~clk;

  // The shift register has no reset; it just follows mode.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    case (sr_mode)
      2'b01:   sr_q <= {sr_q[W-2:0], sr_s_in};
      2'b10:   sr_q <= {sr_s_in, sr_q[W-1:1]};
      2'b11:   sr_q <= sr_p_in;
      default: sr_q <= sr_q;
    endcase
  end
  assign sr_is_zero = (sr_q == '0);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      last_done = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", int'(result), int'(e.res));
        chk("result_zero", int'(result_zero), int'(e.zero));
        chk("shifts_done", int'(shifts_done), e.shifts);
        chk("done_edge", cyc, e.done_cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic dr, input logic [CW-1:0] c,
                      input logic f, input logic expect_done, input logic [W-1:0] er,
                      input logic ez, input int es, input int elat, output int acc);
    int n;
    n = 0;
    cmd_data = d; cmd_dir = dr; cmd_count = c; cmd_fill = f; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
    end else if (expect_done) begin
      exp_q.push_back('{er, ez, es, acc + elat});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data = $urandom_range(0, 15);
    cmd_count = CW'($urandom_range(0, 7));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2, a3, n;
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_sr_mode", int'(sr_mode), 0);
    chk("rst_sr_p_in", int'(sr_p_in), 0);
    chk("rst_sr_s_in", int'(sr_s_in), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_zero", int'(result_zero), 0);
    chk("rst_shifts_done", int'(shifts_done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

    send(4'b0001, 1'b0, 3'd2, 1'b1, 1'b1, 4'b0111, 1'b0, 2, 4, a1);
    chk("busy_during_cmd", int'(busy), 1);
    chk("ready_during_cmd", int'(cmd_ready), 0);
    chk("p_in_held", int'(sr_p_in), 1);

    send(4'b0111, 1'b1, 3'd1, 1'b1, 1'b1, 4'b1011, 1'b0, 1, 3, a2);
    send(4'b1011, 1'b1, 3'd4, 1'b0, 1'b1, 4'b0000, 1'b1, 4, 6, a3);
    chk("back_to_back_accept", a3, a2 + 4);
    chk("back_to_back_after_done", a3, last_done + 1);

    send(4'b0110, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0110, 1'b0, 0, 2, a1);
    send(4'b1001, 1'b0, 3'd7, 1'b1, 1'b1, 4'b1111, 1'b0, 4, 6, a1);
`ifdef SHIFT_ZERO_EARLY_EXIT_EN
    send(4'b0001, 1'b1, 3'd4, 1'b0, 1'b1, 4'b0000, 1'b1, 1, 3, a1);
`else
    send(4'b0001, 1'b1, 3'd4, 1'b0, 1'b1, 4'b0000, 1'b1, 4, 6, a1);
`endif

    // Reset during the second SHIFT cycle: no done, back to IDLE.
    send(4'b1000, 1'b1, 3'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 0, a1);
    @(negedge clk);
    chk("mid_shift_mode", int'(sr_mode), 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sr_mode", int'(sr_mode), 0);
    chk("midrst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", int'(cmd_ready), 1);
    send(4'b1100, 1'b0, 3'd1, 1'b0, 1'b1, 4'b1000, 1'b0, 1, 3, a1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("pending_at_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
